// File: rtl/fetch_mem_if.sv
// Fetch front end: owns the PC and issues one instruction read at a time.
// Fetched {pc, inst} pairs go downstream through a valid/ready handshake.
module fetch_mem_if #(
    parameter int unsigned      DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_PC = 32'h80000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_flag,
    input  logic [DATA_LEN-1:0] jump_pc,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [DATA_LEN-1:0] mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [DATA_LEN-1:0] mem_rsp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_pc,
    output logic [DATA_LEN-1:0] out_inst
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [DATA_LEN-1:0] pc, pc_next;
    logic [DATA_LEN-1:0] inst, inst_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RST_PC;
            inst  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            inst  <= inst_next;
        end
    end

    // A jump always wins the PC update; DROP absorbs the one response that
    // is still in flight for an abandoned address.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_next  = inst;

        unique case (state)
            IDLE: begin
                state_next = REQ;
                if (jump_flag) pc_next = jump_pc;
            end

            REQ: begin
                if (jump_flag) begin
                    pc_next = jump_pc;
                    if (mem_req_ready) state_next = DROP;
                end else if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (jump_flag) begin
                    pc_next    = jump_pc;
                    state_next = mem_rsp_valid ? REQ : DROP;
                end else if (mem_rsp_valid) begin
                    inst_next  = mem_rsp_data;
                    state_next = HOLD;
                end
            end

            DROP: begin
                if (jump_flag)     pc_next    = jump_pc;
                if (mem_rsp_valid) state_next = REQ;
            end

            HOLD: begin
                if (jump_flag) begin
                    pc_next    = jump_pc;
                    state_next = REQ;
                end else if (out_ready) begin
                    pc_next    = pc + DATA_LEN'(4);
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_req_valid = (state == REQ);
    assign out_valid     = (state == HOLD);
    assign mem_req_addr  = pc;
    assign out_pc        = pc;
    assign out_inst      = inst;

endmodule

// File: tb/tb_fetch_mem_if.sv
// Directed bench for fetch_mem_if: a cycle-by-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_fetch_mem_if;

    logic        clk;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        logic        jf;
        logic [31:0] jpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ordy;
        logic        exp_req_valid;
        logic        exp_out_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    fetch_mem_if #(.DATA_LEN(32), .RST_PC(32'h80000000)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag     (jump_flag),
        .jump_pc       (jump_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic jf, input logic [31:0] jpc, input logic rdy,
                                input logic rv, input logic [31:0] rd, input logic ordy,
                                input logic erv, input logic eov, input logic [31:0] epc,
                                input logic [31:0] ei);
        vec_t v;
        v.jf = jf; v.jpc = jpc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ordy = ordy;
        v.exp_req_valid = erv; v.exp_out_valid = eov; v.exp_pc = epc; v.exp_inst = ei;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        jump_flag     = v.jf;
        jump_pc       = v.jpc;
        mem_req_ready = v.rdy;
        mem_rsp_valid = v.rv;
        mem_rsp_data  = v.rd;
        out_ready     = v.ordy;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic erv, input logic eov,
                               input logic [31:0] epc, input logic [31:0] ei);
        checkBit ({tag, " mem_req_valid"}, mem_req_valid, erv);
        checkBit ({tag, " out_valid"},     out_valid,     eov);
        checkWord({tag, " mem_req_addr"},  mem_req_addr,  epc);
        checkWord({tag, " out_pc"},        out_pc,        epc);
        checkWord({tag, " out_inst"},      out_inst,      ei);
    endtask

    task automatic idleInputs();
        jump_flag     = 1'b0;
        jump_pc       = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        out_ready     = 1'b0;
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;

        // Sequential fetch with a 5-cycle stall in HOLD (one stray response included)
        add(0, 0, 1, 0, 0,            1, 1, 0, 32'h80000000, 32'h00000000);
        add(0, 0, 1, 0, 0,            1, 0, 0, 32'h80000000, 32'h00000000);
        add(0, 0, 1, 1, 32'h00000013, 0, 0, 1, 32'h80000000, 32'h00000013);
        add(0, 0, 1, 0, 0,            0, 0, 1, 32'h80000000, 32'h00000013);
        add(0, 0, 1, 0, 0,            0, 0, 1, 32'h80000000, 32'h00000013);
        add(0, 0, 1, 1, 32'hFFFFFFFF, 0, 0, 1, 32'h80000000, 32'h00000013);
        add(0, 0, 1, 0, 0,            0, 0, 1, 32'h80000000, 32'h00000013);
        add(0, 0, 1, 0, 0,            0, 0, 1, 32'h80000000, 32'h00000013);
        add(0, 0, 1, 0, 0,            1, 1, 0, 32'h80000004, 32'h00000013);
        add(0, 0, 1, 0, 0,            1, 0, 0, 32'h80000004, 32'h00000013);
        add(0, 0, 1, 1, 32'h22222222, 1, 0, 1, 32'h80000004, 32'h22222222);
        add(0, 0, 1, 0, 0,            1, 1, 0, 32'h80000008, 32'h22222222);
        add(0, 0, 1, 0, 0,            1, 0, 0, 32'h80000008, 32'h22222222);
        add(0, 0, 1, 1, 32'h33333333, 1, 0, 1, 32'h80000008, 32'h33333333);
        add(0, 0, 1, 0, 0,            1, 1, 0, 32'h8000000C, 32'h33333333);
        // Jump in WAIT, stale response three cycles later
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h8000000C, 32'h33333333);
        add(1, 32'h80001000, 1, 0, 0,            1, 0, 0, 32'h80001000, 32'h33333333);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h80001000, 32'h33333333);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h80001000, 32'h33333333);
        add(0, 0,            1, 1, 32'hDEADBEEF, 1, 1, 0, 32'h80001000, 32'h33333333);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h80001000, 32'h33333333);
        add(0, 0,            1, 1, 32'hAAAA0001, 1, 0, 1, 32'h80001000, 32'hAAAA0001);
        add(0, 0,            1, 0, 0,            1, 1, 0, 32'h80001004, 32'hAAAA0001);
        // Jump in REQ while memory is stalled
        add(1, 32'h80000200, 0, 0, 0,            1, 1, 0, 32'h80000200, 32'hAAAA0001);
        add(0, 0,            0, 0, 0,            1, 1, 0, 32'h80000200, 32'hAAAA0001);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h80000200, 32'hAAAA0001);
        add(0, 0,            1, 1, 32'hBBBB0002, 1, 0, 1, 32'h80000200, 32'hBBBB0002);
        // Jump coinciding with the HOLD handshake
        add(1, 32'h80000040, 1, 0, 0,            1, 1, 0, 32'h80000040, 32'hBBBB0002);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h80000040, 32'hBBBB0002);
        add(0, 0,            1, 1, 32'hCCCC0003, 1, 0, 1, 32'h80000040, 32'hCCCC0003);
        add(0, 0,            1, 0, 0,            1, 1, 0, 32'h80000044, 32'hCCCC0003);
        // Jump on accept, then jump with the dropped response in DROP
        add(1, 32'h80000100, 1, 0, 0,            1, 0, 0, 32'h80000100, 32'hCCCC0003);
        add(1, 32'h80000300, 1, 1, 32'h11112222, 1, 1, 0, 32'h80000300, 32'hCCCC0003);
        // Jump in WAIT with the response in the same cycle
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h80000300, 32'hCCCC0003);
        add(1, 32'h80000400, 1, 1, 32'hDEADBEEF, 1, 1, 0, 32'h80000400, 32'hCCCC0003);
        // PC increment wraps at the top of the address space
        add(1, 32'hFFFFFFFC, 0, 0, 0,            1, 1, 0, 32'hFFFFFFFC, 32'hCCCC0003);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'hFFFFFFFC, 32'hCCCC0003);
        add(0, 0,            1, 1, 32'hDDDD0004, 0, 0, 1, 32'hFFFFFFFC, 32'hDDDD0004);
        add(0, 0,            1, 0, 0,            1, 1, 0, 32'h00000000, 32'hDDDD0004);
        add(0, 0,            1, 0, 0,            1, 0, 0, 32'h00000000, 32'hDDDD0004);

        #1;
        checkOutput("reset", 1'b0, 1'b0, 32'h80000000, 32'h00000000);
        #21;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_req_valid, vecs[i].exp_out_valid,
                        vecs[i].exp_pc, vecs[i].exp_inst);
        end

        // Asynchronous reset while WAIT is pending, then a late response
        idleInputs();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 1'b0, 1'b0, 32'h80000000, 32'h00000000);
        @(posedge clk);
        #1;
        checkOutput("rst_held", 1'b0, 1'b0, 32'h80000000, 32'h00000000);
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hEEEEEEEE;
        @(posedge clk);
        #1;
        checkOutput("late_rsp_idle", 1'b1, 1'b0, 32'h80000000, 32'h00000000);
        @(posedge clk);
        #1;
        checkOutput("late_rsp_req", 1'b1, 1'b0, 32'h80000000, 32'h00000000);
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("restart_wait", 1'b0, 1'b0, 32'h80000000, 32'h00000000);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00000055;
        @(posedge clk);
        #1;
        checkOutput("restart_hold", 1'b0, 1'b1, 32'h80000000, 32'h00000055);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
